// File: rtl/seq_shift_add_mult.sv
// Unsigned radix-2 shift-add sequential multiplier with start/ready/done handshake.
// Optional macro MULT_EARLY_EXIT_EN ends CALC once the remaining multiplier bits are all zero.
module seq_shift_add_mult #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e               r_state, w_state_nxt;
  logic [2*WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [2*WIDTH-1:0]   r_mcand, w_mcand_nxt;
  logic [2*WIDTH-1:0]   r_product, w_product_nxt;
  logic [WIDTH-1:0]     r_mplier, w_mplier_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_done, w_done_nxt;

  logic [2*WIDTH-1:0]   w_acc_sum;
  logic [WIDTH-1:0]     w_mplier_shr;
  logic                 w_last;

  assign w_acc_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_shr = r_mplier >> 1;

`ifdef MULT_EARLY_EXIT_EN
  // No set bits left after this shift: the remaining iterations would add nothing.
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (w_mplier_shr == '0);
`else
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_mcand_nxt   = r_mcand;
    w_mplier_nxt  = r_mplier;
    w_cnt_nxt     = r_cnt;
    w_product_nxt = r_product;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_mcand_nxt  = {{WIDTH{1'b0}}, a_in};
          w_mplier_nxt = b_in;
          w_acc_nxt    = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = StCalc;
        end
      end
      StCalc: begin
        w_acc_nxt    = w_acc_sum;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = w_mplier_shr;
        w_cnt_nxt    = r_cnt + 1'b1;
        if (w_last) begin
          w_product_nxt = w_acc_sum;
          w_done_nxt    = 1'b1;
          w_state_nxt   = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_mcand   <= w_mcand_nxt;
      r_mplier  <= w_mplier_nxt;
      r_cnt     <= w_cnt_nxt;
      r_product <= w_product_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign ready   = (r_state == StIdle);
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult (WIDTH=16); honours MULT_EARLY_EXIT_EN if defined.
module tb_seq_shift_add_mult;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           ready;
  logic           done;
  logic [2*W-1:0] product;

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;

  exp_t           sb_q[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  int             acc_cyc = 0;
  int             done_cyc = -1;
  int             prev_done_cyc = -1;
  logic [2*W-1:0] last_prod = '0;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .ready   (ready),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
    int l;
    l = 1;
    for (int i = 0; i < W; i++) if (b[i]) l = i + 1;
    return l;
`else
    return W;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("product", 64'(product), 64'(e.prod));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
        last_prod     = e.prod;
        prev_done_cyc = done_cyc;
        done_cyc      = cyc;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] p, input bit keep);
    int t;
    exp_t e;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    t = 0;
    while (!ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      check("ready_timeout", 64'(ready), 64'd1);
      start = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    e.prod  = p;
    e.cyc   = cyc + exp_lat(b);
    sb_q.push_back(e);
    if (!keep) start = 1'b0;
    @(negedge clk);
    check("ready_drop", 64'(ready), 64'd0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int d;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    rst = 1'b0;

    // Basic case plus product hold afterwards.
    issue(16'd17, 16'd5, 32'd85, 1'b0);
    wait_idle();
    check("ready_after", 64'(ready), 64'd1);
    repeat (3) @(negedge clk);
    check("product_hold", 64'(product), 64'd85);

    issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0);
    wait_idle();
    issue(16'd0, 16'd1234, 32'd0, 1'b0);
    wait_idle();
    issue(16'd1234, 16'd0, 32'd0, 1'b0);
    wait_idle();
    issue(16'h8000, 16'd2, 32'h00010000, 1'b0);
    wait_idle();
    issue(16'd1, 16'h8000, 32'h00008000, 1'b0);
    wait_idle();

    // start held high and a_in changed mid-CALC: must not re-accept.
    issue(16'd3, 16'd4, 32'd12, 1'b1);
    a_in = 16'd9;
    while (cyc < acc_cyc + exp_lat(16'd4) - 1) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("hold_product", 64'(product), 64'd12);

    // Reset mid-operation abandons the result.
    issue(16'd7, 16'd6, 32'd42, 1'b0);
    d = (exp_lat(16'd6) > 5) ? 5 : exp_lat(16'd6) - 1;
    while (cyc < acc_cyc + d - 1) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_product", 64'(product), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (20) @(negedge clk);
    issue(16'd2, 16'd3, 32'd6, 1'b0);
    wait_idle();

    // Back-to-back with start held across the done cycle.
    issue(16'd10, 16'd10, 32'd100, 1'b1);
    issue(16'd11, 16'd12, 32'd132, 1'b0);
    wait_idle();
    check("b2b_spacing", 64'(done_cyc - prev_done_cyc), 64'(exp_lat(16'd12) + 1));
    check("b2b_product", 64'(product), 64'd132);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
